arb2_rr_sel: RTL and testbench

ARB2_RR_SEL -- requirements
Module: arb2_rr_sel

---
 rtl/arb2_rr_sel.sv | 77 +++++++
 tb/tb_arb2_rr_sel.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/arb2_rr_sel.sv
// arb2_rr_sel: two-source packet arbiter steering a mux2_1 select, round-robin on ties.
// Ports:
//   CLK          rising-edge clock
//   RST          synchronous active-high reset
//   REQ0/REQ1    source valid beat (data on mux D0/D1)
//   LAST0/LAST1  beat ends its packet, sampled only with the matching REQ
//   READY        downstream accepts the beat on Y
//   S            registered mux select (0 = D0, 1 = D1)
//   GNT0/GNT1    registered one-hot grant, both low when idle
//   VALID        combinational beat-valid on Y
//   BEATS        beats accepted in the current grant
module arb2_rr_sel #(
    parameter int MAX_BEATS = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       LAST0,
    input  logic       LAST1,
    input  logic       READY,
    output logic       S,
    output logic       GNT0,
    output logic       GNT1,
    output logic       VALID,
    output logic [3:0] BEATS
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t     r_state;
    logic       r_s;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_pri;
    logic [3:0] r_beats;

    logic w_xfer;
    logic w_last;
    logic w_release;
    logic w_enter;
    logic w_nidx;

    assign VALID     = (r_gnt0 & REQ0) | (r_gnt1 & REQ1);
    assign w_xfer    = VALID & READY;
    assign w_last    = r_gnt1 ? LAST1 : LAST0;
    assign w_release = w_xfer & (w_last | ((r_beats + 4'd1) == 4'(MAX_BEATS)));
    assign w_enter   = ((r_state == IDLE) & (REQ0 | REQ1)) | w_release;
    // On release the granted source is requesting (it just transferred), so a
    // release always re-grants: the other source if it asks, otherwise the same one.
    assign w_nidx    = (r_state == IDLE) ? ((REQ0 & REQ1) ? r_pri : REQ1)
                                         : (r_gnt0 ? REQ1 : ~REQ0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_s     <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_pri   <= 1'b0;
            r_beats <= 4'd0;
        end else if (w_enter) begin
            r_state <= w_nidx ? GRANT1 : GRANT0;
            r_s     <= w_nidx;
            r_gnt0  <= ~w_nidx;
            r_gnt1  <= w_nidx;
            r_pri   <= ~w_nidx;
            r_beats <= 4'd0;
        end else if (w_xfer) begin
            r_beats <= r_beats + 4'd1;
        end
    end

    assign S     = r_s;
    assign GNT0  = r_gnt0;
    assign GNT1  = r_gnt1;
    assign BEATS = r_beats;
endmodule

// File: tb/tb_arb2_rr_sel.sv
// tb_arb2_rr_sel: directed self-checking bench for arb2_rr_sel.
module tb_arb2_rr_sel;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ0 = 1'b0;
    logic       REQ1 = 1'b0;
    logic       LAST0 = 1'b0;
    logic       LAST1 = 1'b0;
    logic       READY = 1'b0;
    logic       S;
    logic       GNT0;
    logic       GNT1;
    logic       VALID;
    logic [3:0] BEATS;

    logic [7:0] d0 = 8'hA5;
    logic [7:0] d1 = 8'h3C;
    logic [7:0] y;
    logic       prev_idle = 1'b0;
    logic       prev_s = 1'b0;
    int         total = 0;
    int         bad = 0;

    arb2_rr_sel #(.MAX_BEATS(8)) dut (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .LAST0(LAST0), .LAST1(LAST1),
        .READY(READY), .S(S), .GNT0(GNT0), .GNT1(GNT1), .VALID(VALID), .BEATS(BEATS)
    );

    always #5 CLK = ~CLK;
    assign y = S ? d1 : d0;

    // Advance one cycle and apply the per-cycle invariants.
    task automatic tick();
        @(posedge CLK);
        #1;
        total++;
        if ((GNT0 & GNT1) !== 1'b0) begin
            bad++;
            $display("FAIL onehot: GNT0=%b GNT1=%b required not both high", GNT0, GNT1);
        end
        if (GNT0 || GNT1) begin
            total++;
            if (S !== GNT1) begin
                bad++;
                $display("FAIL sel_match: S=%b required %b", S, GNT1);
            end
        end
        if (prev_idle && !GNT0 && !GNT1) begin
            total++;
            if (S !== prev_s) begin
                bad++;
                $display("FAIL idle_hold: S=%b required %b", S, prev_s);
            end
        end
        if (VALID === 1'b1) begin
            total++;
            if (y !== (GNT1 ? d1 : d0)) begin
                bad++;
                $display("FAIL mux_y: y=%h required %h", y, GNT1 ? d1 : d0);
            end
        end
        prev_idle = !GNT0 && !GNT1;
        prev_s = S;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0; LAST0 = 1'b0; LAST1 = 1'b0; READY = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({S, GNT0, GNT1, VALID, BEATS} !== 8'h00) begin
            bad++;
            $display("FAIL reset: S=%b GNT=%b%b VALID=%b BEATS=%0d required all 0", S, GNT1, GNT0, VALID, BEATS);
        end
        tick();
        total++;
        if ({GNT0, GNT1} !== 2'b00) begin
            bad++;
            $display("FAIL idle_no_req: GNT=%b%b required 00", GNT1, GNT0);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        REQ0 = 1'b1; REQ1 = 1'b1; LAST0 = 1'b1; LAST1 = 1'b1; READY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if ({GNT1, GNT0, S, BEATS} !== {(i % 2 == 1), (i % 2 == 0), (i % 2 == 1), 4'd0}) begin
                bad++;
                $display("FAIL alternate[%0d]: GNT=%b%b S=%b BEATS=%0d required GNT=%b%b S=%b BEATS=0",
                         i, GNT1, GNT0, S, BEATS, i % 2 == 1, i % 2 == 0, i % 2 == 1);
            end
        end
    endtask

    task automatic test_idle_req1();
        do_reset();
        REQ1 = 1'b1; READY = 1'b0;
        tick();
        total++;
        if ({GNT1, GNT0, S, VALID} !== 4'b1011) begin
            bad++;
            $display("FAIL idle_req1: GNT=%b%b S=%b VALID=%b required GNT=10 S=1 VALID=1", GNT1, GNT0, S, VALID);
        end
    endtask

    task automatic test_last3();
        do_reset();
        REQ0 = 1'b1; READY = 1'b1; LAST0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (GNT0 !== 1'b1 || BEATS !== 4'(i)) begin
                bad++;
                $display("FAIL last3_beat[%0d]: GNT0=%b BEATS=%0d required GNT0=1 BEATS=%0d", i, GNT0, BEATS, i);
            end
        end
        LAST0 = 1'b1;
        tick();
        LAST0 = 1'b0;
        total++;
        if (GNT0 !== 1'b1 || BEATS !== 4'd0) begin
            bad++;
            $display("FAIL last3_regrant: GNT0=%b BEATS=%0d required GNT0=1 BEATS=0", GNT0, BEATS);
        end
        tick();
        total++;
        if (BEATS !== 4'd1) begin
            bad++;
            $display("FAIL last3_count: BEATS=%0d required 1", BEATS);
        end
    endtask

    task automatic test_forced_then_stall();
        do_reset();
        REQ0 = 1'b1; REQ1 = 1'b1; READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (GNT0 !== 1'b1 || BEATS !== 4'(i)) begin
                bad++;
                $display("FAIL forced_beat[%0d]: GNT0=%b BEATS=%0d required GNT0=1 BEATS=%0d", i, GNT0, BEATS, i);
            end
        end
        tick();
        total++;
        if ({GNT1, GNT0, S, BEATS} !== 7'b1010000) begin
            bad++;
            $display("FAIL forced_release: GNT=%b%b S=%b BEATS=%0d required GNT=10 S=1 BEATS=0", GNT1, GNT0, S, BEATS);
        end
        // Source 0 keeps requesting with LAST0 set: it must not disturb GRANT1.
        LAST0 = 1'b1;
        tick();
        READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({VALID, GNT1, S, BEATS} !== 7'b1110001) begin
                bad++;
                $display("FAIL stall[%0d]: VALID=%b GNT1=%b S=%b BEATS=%0d required VALID=1 GNT1=1 S=1 BEATS=1",
                         i, VALID, GNT1, S, BEATS);
            end
        end
        READY = 1'b1;
        tick();
        total++;
        if (GNT1 !== 1'b1 || BEATS !== 4'd2) begin
            bad++;
            $display("FAIL stall_done: GNT1=%b BEATS=%0d required GNT1=1 BEATS=2", GNT1, BEATS);
        end
        REQ1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({VALID, GNT1, GNT0, BEATS} !== 7'b0100010) begin
                bad++;
                $display("FAIL req_drop[%0d]: VALID=%b GNT=%b%b BEATS=%0d required VALID=0 GNT=10 BEATS=2",
                         i, VALID, GNT1, GNT0, BEATS);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        REQ0 = 1'b1; READY = 1'b1; LAST0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (GNT0 !== 1'b1 || BEATS !== 4'd3) begin
            bad++;
            $display("FAIL mid_pre: GNT0=%b BEATS=%0d required GNT0=1 BEATS=3", GNT0, BEATS);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total++;
        if ({S, GNT1, GNT0, BEATS, VALID} !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset: S=%b GNT=%b%b BEATS=%0d VALID=%b required all 0", S, GNT1, GNT0, BEATS, VALID);
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_idle_req1();
        test_last3();
        test_forced_then_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
